// File: rtl/store_capture_fifo.sv
// -----------------------------------------------------------------------------
// store_capture_fifo
//   Snoops the CPU data-memory write port and queues every store whose address
//   lies in [ADDR_LO, ADDR_HI] into a DEPTH-entry FIFO. The FIFO drains through
//   a valid/ready port towards a debug sink. Also counts store cycles
//   (saturating) and raises a sticky flag when the completion-signature store
//   (DONE_DATA written to DONE_ADR) is seen.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous clear of FIFO, counters and flags
//   MemWrite   in   store strobe, one store per high cycle
//   DataAdr    in   store address
//   WriteData  in   store data
//   out_valid  out  FIFO head valid
//   out_ready  in   sink accepts head this cycle
//   out_adr    out  head entry address (0 when empty)
//   out_data   out  head entry data (0 when empty)
//   level      out  number of queued entries, 0..DEPTH
//   overflow   out  sticky: a captured store was dropped because FIFO was full
//   store_cnt  out  saturating count of MemWrite cycles
//   done       out  sticky: signature store seen
// -----------------------------------------------------------------------------
module store_capture_fifo #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] ADDR_LO   = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI   = 32'h0000_00FF,
   parameter logic [31:0] DONE_ADR  = 32'h0000_0064,
   parameter logic [31:0] DONE_DATA = 32'd7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     MemWrite,
   input  logic [31:0]              DataAdr,
   input  logic [31:0]              WriteData,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_adr,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [15:0]              store_cnt,
   output logic                     done
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [63:0]   mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   store_cnt_q, store_cnt_d;
   logic          done_q, done_d;

   logic          full;
   logic          empty;
   logic          in_window;
   logic          capture;
   logic          push;
   logic          pop;
   logic          done_hit;
   logic          mem_we;
   logic [63:0]   head;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);

   // A constant leading 1 on both operands keeps the compare unsigned and
   // non-degenerate even when a window bound sits at 0 or all-ones.
   assign in_window = ({1'b1, DataAdr} >= {1'b1, ADDR_LO}) &&
                      ({1'b1, DataAdr} <= {1'b1, ADDR_HI});

   assign capture  = MemWrite && in_window;
   assign pop      = !empty && out_ready;
   assign push     = capture && (!full || pop);
   assign done_hit = MemWrite && (DataAdr == DONE_ADR) && (WriteData == DONE_DATA);
   assign mem_we   = push && !clear;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      store_cnt_d = store_cnt_q;
      done_d      = done_q;

      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         store_cnt_d = '0;
         done_d      = 1'b0;
      end else begin
         // DEPTH is a power of two, so pointer increments wrap naturally.
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

         unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase

         if (capture && !push)            overflow_d  = 1'b1;
         if (MemWrite && store_cnt_q != '1) store_cnt_d = store_cnt_q + 1'b1;
         if (done_hit)                    done_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         store_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         store_cnt_q <= store_cnt_d;
         done_q      <= done_d;
      end
   end

   // Storage needs no reset: the output is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= {DataAdr, WriteData};
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = !empty;
   assign out_adr   = out_valid ? head[63:32] : '0;
   assign out_data  = out_valid ? head[31:0]  : '0;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign store_cnt = store_cnt_q;
   assign done      = done_q;

endmodule

// File: tb/tb_store_capture_fifo.sv
module tb_store_capture_fifo;

   localparam int          DEPTH  = 8;
   localparam logic [31:0] HI     = 32'h0000_00FF;  // window low bound is 0
   localparam logic [31:0] DONE_A = 32'h0000_0064;
   localparam logic [31:0] DONE_D = 32'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_adr;
   logic [31:0] out_data;
   logic [3:0]  level;
   logic        overflow;
   logic [15:0] store_cnt;
   logic        done;

   store_capture_fifo #(
      .DEPTH(DEPTH), .ADDR_LO(32'h0), .ADDR_HI(HI),
      .DONE_ADR(DONE_A), .DONE_DATA(DONE_D)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_adr(out_adr), .out_data(out_data),
      .level(level), .overflow(overflow), .store_cnt(store_cnt), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: the queue holds entries expected at the drain port,
   // in acceptance order; scalars track the expected counters/flags.
   logic [63:0] sb_q[$];
   int          m_lvl = 0;
   logic        m_ovf = 1'b0;
   int          m_cnt = 0;
   logic        m_done = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic flush_model();
      sb_q.delete();
      m_lvl  = 0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
   endtask

   task automatic check_state();
      chk("level",     64'(level),     64'(m_lvl));
      chk("out_valid", 64'(out_valid), 64'(m_lvl > 0));
      chk("overflow",  64'(overflow),  64'(m_ovf));
      chk("store_cnt", 64'(store_cnt), 64'(m_cnt));
      chk("done",      64'(done),      64'(m_done));
      if (m_lvl > 0 && sb_q.size() > 0)
         chk("head", {out_adr, out_data}, sb_q[0]);
      else
         chk("idle_out", {out_adr, out_data}, 64'd0);
   endtask

   // Called at posedge+1: issue one cycle of stimulus, predict, then check.
   task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr);
      logic cap, pp, acc;
      MemWrite  = mw;
      DataAdr   = a;
      WriteData = d;
      out_ready = rdy;
      clear     = clr;
      if (clr) begin
         flush_model();
      end else begin
         pp  = (m_lvl > 0) && rdy;
         cap = mw && (a <= HI);
         acc = cap && (m_lvl < DEPTH || pp);
         if (acc) sb_q.push_back({a, d});
         m_lvl = m_lvl + (acc ? 1 : 0) - (pp ? 1 : 0);
         if (cap && !acc) m_ovf = 1'b1;
         if (mw && m_cnt != 65535) m_cnt++;
         if (mw && a == DONE_A && d == DONE_D) m_done = 1'b1;
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic idle_inputs();
      MemWrite  = 1'b0;
      out_ready = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic async_reset();
      idle_inputs();
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_level", 64'(level), 64'd0);
      flush_model();
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check_state();
   endtask

   // Monitor: a handshake seen mid-cycle retires the oldest expected entry.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         if (reset && !clear && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pop", {out_adr, out_data}, 64'd0);
               failures += (out_valid ? 0 : 1);
            end else begin
               exp = sb_q.pop_front();
               chk("drain", {out_adr, out_data}, exp);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      logic [31:0] a, d;
      logic mw, rdy, clr;

      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      check_state();
      @(posedge clk);
      #1 reset = 1'b1;

      // Signature store into an empty FIFO.
      step(1'b1, DONE_A, DONE_D, 1'b0, 1'b0);
      chk("t1_adr",  64'(out_adr),  64'h64);
      chk("t1_done", 64'(done),     64'd1);
      chk("t1_cnt",  64'(store_cnt), 64'd1);

      // Out-of-window store.
      step(1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h200, DONE_D, 1'b0, 1'b0);
      chk("t2_level", 64'(level), 64'd0);

      // Fill then overflow with no drain.
      step(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++)
         step(1'b1, 32'(i * 4), 32'(32'hA0 + i), 1'b0, 1'b0);
      chk("t3_level", 64'(level), 64'd8);
      chk("t3_ovf",   64'(overflow), 64'd1);
      chk("t3_head",  {out_adr, out_data}, {32'd0, 32'hA0});

      // Full with simultaneous push and pop, across pointer wrap.
      step(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'(i + 16), 32'(32'hB0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         step(1'b1, 32'(i + 64), 32'(32'hC0 + i), 1'b1, 1'b0);
      chk("t4_level", 64'(level), 64'd8);
      chk("t4_ovf",   64'(overflow), 64'd0);
      for (int i = 0; i < 9; i++)
         step(1'b0, '0, '0, 1'b1, 1'b0);

      // Clear beats a simultaneous store (the signature store, even).
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(i + 8), 32'(i), 1'b0, 1'b0);
      step(1'b1, DONE_A, DONE_D, 1'b1, 1'b1);
      chk("t5_level", 64'(level), 64'd0);
      chk("t5_done",  64'(done), 64'd0);

      // Async reset mid-drain.
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(i + 32), 32'(32'hD0 + i), 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      async_reset();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         clr = ($urandom_range(0, 99) < 2);
         mw  = ($urandom_range(0, 3) != 0);
         rdy = (n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         sel = int'($urandom_range(0, 9));
         d   = $urandom;
         if (sel < 6) begin
            a = 32'($urandom_range(0, 255));
         end else if (sel < 8) begin
            a = DONE_A;
            d = 32'($urandom_range(6, 8));
         end else begin
            a = 32'h100 + $urandom_range(0, 32'hFFFF);
         end
         step(mw, a, d, rdy, clr);
      end

      for (int i = 0; i < 12; i++)
         step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("final_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
